pkt_port_tx: RTL and testbench

//  Egress transmitter for one switch port: the sending end of the packet byte-stream
//  (package_out / package_out_start / read_data_valid / package_ack).

---
 rtl/pkt_port_tx.sv | 137 +++++++++++++
 tb/tb_pkt_port_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_port_tx.sv
// Egress transmitter for one switch port: store-and-forward byte FIFO feeding a
// start/ack handshake, with ack-timeout packet drop and saturating statistics.
//
// state | meaning
// IDLE  | waiting for a complete packet in the FIFO
// START | first byte presented with start strobe, waiting for package_ack
// SEND  | streaming remaining bytes, one per cycle
// DROP  | discarding the rest of an unacknowledged packet
module pkt_port_tx #(
  parameter int DEPTH       = 64,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  package_out,
  output logic        package_out_start,
  output logic        read_data_valid,
  input  logic        package_ack,
  output logic        tx_busy,
  output logic [15:0] pkt_sent_cnt,
  output logic [15:0] pkt_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, DROP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pkt_cnt;
  logic            push;
  logic            pop;
  logic            head_last;
  logic [7:0]      head_data;

  assign wr_ready  = (count != CW'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign head_last = mem[rd_ptr][8];
  assign head_data = mem[rd_ptr][7:0];

  always_comb begin
    pop = 1'b0;
    unique case (state)
      START:      pop = package_ack || (timer == TIMER_MAX);
      SEND, DROP: pop = 1'b1;
      default:    pop = 1'b0;
    endcase
  end

  // Output decode straight off the state register, so reset clears them at once.
  assign package_out_start = (state == START);
  assign read_data_valid   = (state == START) || (state == SEND);
  assign package_out       = read_data_valid ? head_data : 8'h00;
  assign tx_busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if ((push && wr_last) && !(pop && head_last))      pkt_cnt <= pkt_cnt + 1'b1;
      else if (!(push && wr_last) && (pop && head_last)) pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      pkt_sent_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pkt_cnt != '0) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (package_ack) begin
            if (head_last) begin
              state <= IDLE;
              if (pkt_sent_cnt != 16'hFFFF) pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            end else begin
              state <= SEND;
            end
          end else if (timer == TIMER_MAX) begin
            if (head_last) begin
              state <= IDLE;
              if (pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            end else begin
              state <= DROP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SEND: begin
          if (head_last) begin
            state <= IDLE;
            if (pkt_sent_cnt != 16'hFFFF) pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
          end
        end
        DROP: begin
          if (head_last) begin
            state <= IDLE;
            if (pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_port_tx.sv
// Bench for pkt_port_tx: table of packets plus hand sequences for full FIFO,
// back-to-back packets and mid-packet reset; egress checked against a byte scoreboard.
module tb_pkt_port_tx;

  localparam int DEPTH  = 64;
  localparam int ACK_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_last = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  package_out;
  logic        package_out_start;
  logic        read_data_valid;
  logic        package_ack = 1'b0;
  logic        tx_busy;
  logic [15:0] pkt_sent_cnt;
  logic [15:0] pkt_drop_cnt;

  pkt_port_tx #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .package_out(package_out), .package_out_start(package_out_start),
    .read_data_valid(read_data_valid), .package_ack(package_ack),
    .tx_busy(tx_busy), .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       drop;
  } exp_t;

  typedef struct {
    int         len;
    logic [7:0] first;
    logic [7:0] base;
    int         ack_delay;
    int         exp_sent;
    int         exp_drop;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   ack_delay = 0;
  int   run = 0;
  int   sent_exp = 0;
  int   drop_exp = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Receiver model: acks after ack_delay START cycles (negative = never) and scores bytes.
  always @(negedge clk) begin
    if (!rst) begin
      run = 0;
      package_ack = 1'b0;
    end else if (package_out_start) begin
      run++;
      package_ack = (ack_delay >= 0) && (run > ack_delay);
      chk("start_with_valid", 32'(read_data_valid), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_start", 32'(package_out), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb[0];
        chk("start_byte", 32'(package_out), 32'(mon_e.data));
        chk("start_is_first", 32'(mon_e.first), 32'd1);
        if (package_ack) begin
          chk("acked_not_drop", 32'(mon_e.drop), 32'd0);
          void'(sb.pop_front());
        end else if (run == ACK_TO) begin
          chk("timeout_drop", 32'(mon_e.drop), 32'd1);
          void'(sb.pop_front());
        end
      end
    end else begin
      run = 0;
      package_ack = 1'b0;
      if (read_data_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", 32'(package_out), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("send_byte", 32'(package_out), 32'(mon_e.data));
          chk("send_not_first", 32'(mon_e.first), 32'd0);
        end
      end else begin
        chk("out_zero_when_idle", 32'(package_out), 32'd0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic l);
    wr_data  = d;
    wr_last  = l;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_sent"}, 32'(pkt_sent_cnt), 32'(sent_exp));
    chk({tag, "_drop"}, 32'(pkt_drop_cnt), 32'(drop_exp));
    chk({tag, "_busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic [7:0] d;
    bit         seen;
    bit         ended;
    logic [6:0] pat;

    vecs[0] = '{3, 8'hA5, 8'h00,  0, 1, 0};
    vecs[1] = '{3, 8'hA5, 8'h00,  5, 2, 0};
    vecs[2] = '{4, 8'h30, 8'h30, -1, 2, 1};
    vecs[3] = '{1, 8'h7E, 8'h00,  0, 3, 1};
    vecs[4] = '{8, 8'h40, 8'h40,  2, 4, 1};
    vecs[5] = '{2, 8'hC3, 8'hC3, -1, 4, 2};
    vecs[6] = '{5, 8'h10, 8'h10, 15, 5, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_out", 32'(package_out), 32'd0);
    chk("rst_start", 32'(package_out_start), 32'd0);
    chk("rst_valid", 32'(read_data_valid), 32'd0);
    chk_counters("rst");
    #2 rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      ack_delay = vecs[v].ack_delay;
      for (int i = 0; i < vecs[v].len; i++) begin
        d = (i == 0) ? vecs[v].first : vecs[v].base + 8'(i);
        if (i == 0 || ack_delay >= 0)
          sb.push_back('{d, (i == 0), (ack_delay < 0)});
        push_byte(d, (i == vecs[v].len - 1));
      end
      if (v == 0) begin
        @(negedge clk);
        chk("latency_idle", 32'(package_out_start), 32'd0);
        @(negedge clk);
        chk("latency_start", 32'(package_out_start), 32'd1);
      end
      wait_idle(200);
      sent_exp = vecs[v].exp_sent;
      drop_exp = vecs[v].exp_drop;
      chk_counters($sformatf("vec%0d", v));
    end

    // Full FIFO with a 64-byte packet; the extra write must be ignored
    ack_delay = 3;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'(i * 3 + 1);
      sb.push_back('{d, (i == 0), 1'b0});
      push_byte(d, (i == DEPTH - 1));
    end
    @(negedge clk);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    push_byte(8'hFF, 1'b1);
    seen  = 1'b0;
    ended = 1'b0;
    for (int i = 0; i < 40 && !ended; i++) begin
      @(negedge clk);
      if (package_out_start) seen = 1'b1;
      else if (seen) ended = 1'b1;
    end
    chk("full_start_ended", 32'(ended), 32'd1);
    chk("full_ready_after_pop", 32'(wr_ready), 32'd1);
    wait_idle(200);
    sent_exp++;
    chk_counters("full");

    // Back-to-back 1-byte packets; 33 pushed on the same edge 11 is popped
    ack_delay = 0;
    pat = 7'b0101010;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        d = 8'h11 * 8'(i + 1);
        sb.push_back('{d, 1'b1, 1'b0});
        wr_data  = d;
        wr_last  = 1'b1;
        wr_valid = 1'b1;
      end else begin
        wr_valid = 1'b0;
        wr_last  = 1'b0;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("b2b_start%0d", i), 32'(package_out_start), 32'(pat[6-i]));
      chk($sformatf("b2b_busy%0d", i), 32'(tx_busy), 32'(pat[6-i]));
    end
    wait_idle(50);
    sent_exp += 3;
    chk_counters("b2b");

    // Reset in the middle of an 8-byte packet
    ack_delay = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'hE0 + 8'(i);
      sb.push_back('{d, (i == 0), 1'b0});
      push_byte(d, (i == 7));
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (read_data_valid && !package_out_start) seen = 1'b1;
    end
    chk("mid_reached_send", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(read_data_valid), 32'd0);
    chk("mid_rst_start", 32'(package_out_start), 32'd0);
    chk("mid_rst_out", 32'(package_out), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd1);
    sb.delete();
    sent_exp = 0;
    drop_exp = 0;
    chk_counters("mid_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'h90 + 8'(i);
      sb.push_back('{d, (i == 0), 1'b0});
      push_byte(d, (i == 4));
    end
    wait_idle(100);
    sent_exp = 1;
    chk_counters("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
